// File: rtl/pipeline_issue_stage.sv
// Context store and round-robin issue stage at the head of the lcisc pipeline.
// The stage holds per-thread contexts and shared/data storage, and commits the
// pipeline-tail writeback back into that storage.
package EV_types;
  localparam int ContextThreadLength = 4;
  localparam int DataStorageLength   = 8;

  typedef logic [$clog2(ContextThreadLength)-1:0] thread_id_t;
  typedef logic [$clog2(DataStorageLength)-1:0]   data_address_t;

  typedef union packed { logic [1:0][31:0] u32; logic [7:0][7:0]  u8;  } thread_register_size;
  typedef union packed { logic [3:0][31:0] u32; logic [15:0][7:0] u8;  } program_instruction_size;
  typedef union packed { logic [1:0][31:0] u32; logic [63:0]      u64; } data_register_size;
  typedef union packed { logic [1:0][31:0] u32; logic [63:0]      u64; } shared_register_size;

  typedef struct packed {
    logic          active_thread;
    thread_id_t    id;
    data_address_t data_address;
  } system_info_t;

  typedef struct packed {
    system_info_t            system;
    thread_register_size     thread;
    program_instruction_size instuctions;
    shared_register_size     shared;
    data_register_size       data;
  } pipeline_pass_structure_t;
endpackage

module pipeline_issue_stage
  import EV_types::*;
#(
  parameter int THREADS    = ContextThreadLength,
  parameter int DATA_DEPTH = DataStorageLength
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  thread_id_t               load_id,
  input  thread_register_size      load_thread,
  input  program_instruction_size  load_instr,
  input  data_address_t            load_data_address,
  output logic                     host_wr_ready,
  input  logic                     data_wr_en,
  input  data_address_t            data_wr_addr,
  input  data_register_size        data_wr_value,
  input  logic                     shared_wr_en,
  input  shared_register_size      shared_wr_value,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output pipeline_pass_structure_t issue_bus,
  input  logic                     wb_valid,
  input  pipeline_pass_structure_t wb_bus,
  output logic                     idle,
  output logic                     wb_error
);

  logic [THREADS-1:0]       active_q, active_d, inflight_q, inflight_d;
  thread_register_size      thread_q [THREADS];
  thread_register_size      thread_d [THREADS];
  program_instruction_size  instr_q  [THREADS];
  program_instruction_size  instr_d  [THREADS];
  data_address_t            daddr_q  [THREADS];
  data_address_t            daddr_d  [THREADS];
  data_register_size        data_q   [DATA_DEPTH];
  data_register_size        data_d   [DATA_DEPTH];
  shared_register_size      shared_q, shared_d;
  thread_id_t               rr_q, rr_d;
  logic                     issue_valid_q, issue_valid_d;
  pipeline_pass_structure_t issue_bus_q, issue_bus_d;
  logic                     wb_error_q, wb_error_d;

  thread_id_t wb_id, cand, idx;
  logic       wb_hit, load_fire, cand_found;

  assign wb_id         = wb_bus.system.id;
  assign wb_hit        = wb_valid && inflight_q[wb_id];
  assign load_ready    = !inflight_q[load_id] && !wb_valid;
  assign host_wr_ready = !wb_valid;
  assign load_fire     = load_valid && load_ready;

  always_comb begin
    active_d      = active_q;
    inflight_d    = inflight_q;
    thread_d      = thread_q;
    instr_d       = instr_q;
    daddr_d       = daddr_q;
    data_d        = data_q;
    shared_d      = shared_q;
    rr_d          = rr_q;
    issue_valid_d = issue_valid_q;
    issue_bus_d   = issue_bus_q;
    wb_error_d    = wb_error_q;
    cand          = '0;
    cand_found    = 1'b0;
    idx           = '0;

    // Storage updates first so the issue capture below sees same-cycle writes.
    if (wb_valid) begin
      if (wb_hit) begin
        thread_d[wb_id]                  = wb_bus.thread;
        instr_d[wb_id]                   = wb_bus.instuctions;
        daddr_d[wb_id]                   = wb_bus.system.data_address;
        shared_d                         = wb_bus.shared;
        data_d[wb_bus.system.data_address] = wb_bus.data;
        active_d[wb_id]                  = wb_bus.system.active_thread;
        inflight_d[wb_id]                = 1'b0;
      end else begin
        wb_error_d = 1'b1;
      end
    end else begin
      if (data_wr_en)   data_d[data_wr_addr] = data_wr_value;
      if (shared_wr_en) shared_d = shared_wr_value;
      if (load_fire) begin
        thread_d[load_id] = load_thread;
        instr_d[load_id]  = load_instr;
        daddr_d[load_id]  = load_data_address;
        active_d[load_id] = 1'b1;
      end
    end

    // Descending scan so the thread closest after rr is the last (winning) match.
    // A writeback-freed thread is still inflight_q here, so it waits one cycle.
    for (int k = THREADS; k >= 1; k--) begin
      idx = thread_id_t'((int'(rr_q) + k) % THREADS);
      if (active_d[idx] && !inflight_q[idx]) begin
        cand       = idx;
        cand_found = 1'b1;
      end
    end

    if (!issue_valid_q || issue_ready) begin
      issue_valid_d = cand_found;
      if (cand_found) begin
        issue_bus_d.system.active_thread = 1'b1;
        issue_bus_d.system.id            = cand;
        issue_bus_d.system.data_address  = daddr_d[cand];
        issue_bus_d.thread               = thread_d[cand];
        issue_bus_d.instuctions          = instr_d[cand];
        issue_bus_d.shared               = shared_d;
        issue_bus_d.data                 = data_d[daddr_d[cand]];
        inflight_d[cand]                 = 1'b1;
        rr_d                             = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q      <= '0;
      inflight_q    <= '0;
      shared_q      <= '0;
      rr_q          <= thread_id_t'(THREADS - 1);
      issue_valid_q <= 1'b0;
      issue_bus_q   <= '0;
      wb_error_q    <= 1'b0;
      for (int i = 0; i < THREADS; i++) begin
        thread_q[i] <= '0;
        instr_q[i]  <= '0;
        daddr_q[i]  <= '0;
      end
      for (int j = 0; j < DATA_DEPTH; j++) data_q[j] <= '0;
    end else begin
      active_q      <= active_d;
      inflight_q    <= inflight_d;
      shared_q      <= shared_d;
      rr_q          <= rr_d;
      issue_valid_q <= issue_valid_d;
      issue_bus_q   <= issue_bus_d;
      wb_error_q    <= wb_error_d;
      thread_q      <= thread_d;
      instr_q       <= instr_d;
      daddr_q       <= daddr_d;
      data_q        <= data_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_bus   = issue_bus_q;
  assign wb_error    = wb_error_q;
  assign idle        = !(|active_q) && !(|inflight_q);

endmodule

// File: tb/tb_pipeline_issue_stage.sv
// Directed bench for pipeline_issue_stage: a per-cycle vector table followed by
// hand-written sequences for stall hold, throughput, bypass and mid-run reset.
module tb_pipeline_issue_stage;
  import EV_types::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     load_valid, load_ready;
  thread_id_t               load_id;
  thread_register_size      load_thread;
  program_instruction_size  load_instr;
  data_address_t            load_data_address;
  logic                     host_wr_ready;
  logic                     data_wr_en;
  data_address_t            data_wr_addr;
  data_register_size        data_wr_value;
  logic                     shared_wr_en;
  shared_register_size      shared_wr_value;
  logic                     issue_valid, issue_ready;
  pipeline_pass_structure_t issue_bus;
  logic                     wb_valid;
  pipeline_pass_structure_t wb_bus;
  logic                     idle, wb_error;

  always #5 clk = ~clk;

  pipeline_issue_stage dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_id(load_id),
    .load_thread(load_thread), .load_instr(load_instr), .load_data_address(load_data_address),
    .host_wr_ready(host_wr_ready),
    .data_wr_en(data_wr_en), .data_wr_addr(data_wr_addr), .data_wr_value(data_wr_value),
    .shared_wr_en(shared_wr_en), .shared_wr_value(shared_wr_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_bus(issue_bus),
    .wb_valid(wb_valid), .wb_bus(wb_bus),
    .idle(idle), .wb_error(wb_error)
  );

  typedef struct {
    logic        lv;   logic [1:0] lid;  logic [31:0] lthr; logic [2:0] lda;
    logic        dwe;  logic [2:0] dwa;  logic [31:0] dwv;
    logic        irdy;
    logic        wbv;  logic [1:0] wbid; logic [31:0] wbthr; logic [2:0] wbda;
    logic [31:0] wbdat; logic wbact;
    logic        lr;   logic iv;   logic [1:0] iid; logic [31:0] ithr; logic [31:0] idat;
    logic        eidle; logic err;
  } vec_t;

  vec_t vecs [20];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic quiet_inputs(input logic irdy);
    load_valid = 1'b0; load_id = '0; load_thread = '0; load_instr = '0; load_data_address = '0;
    data_wr_en = 1'b0; data_wr_addr = '0; data_wr_value = '0;
    shared_wr_en = 1'b0; shared_wr_value = '0;
    issue_ready = irdy; wb_valid = 1'b0; wb_bus = '0;
  endtask

  task automatic set_load(input logic [1:0] id, input logic [31:0] thr, input logic [2:0] da);
    load_valid = 1'b1; load_id = id; load_thread = '0; load_thread.u32[0] = thr;
    load_data_address = da;
  endtask

  task automatic set_wb(input logic [1:0] id, input logic [31:0] thr, input logic [2:0] da,
                        input logic [31:0] dat, input logic act);
    wb_valid = 1'b1; wb_bus = '0;
    wb_bus.system.id = id; wb_bus.system.data_address = da; wb_bus.system.active_thread = act;
    wb_bus.thread.u32[0] = thr; wb_bus.data.u32[0] = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    quiet_inputs(v.irdy);
    if (v.lv) set_load(v.lid, v.lthr, v.lda);
    load_id = v.lid;
    data_wr_en = v.dwe; data_wr_addr = v.dwa; data_wr_value.u32[0] = v.dwv;
    if (v.wbv) set_wb(v.wbid, v.wbthr, v.wbda, v.wbdat, v.wbact);
  endtask

  initial begin
    //          lv lid lthr       lda dwe dwa dwv       irdy wbv wbid wbthr      wbda wbdat      wbact lr iv iid ithr       idat       idle err
    vecs[0]  = '{0, 0, 32'h0,     0,  1,  2,  32'hA5,   1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 0, 0,  32'h0,     32'h0,     1,   0};
    vecs[1]  = '{1, 0, 32'h100,   2,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 1, 0,  32'h100,   32'hA5,    0,   0};
    vecs[2]  = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    0, 0, 0,  32'h0,     32'h0,     0,   0};
    vecs[3]  = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    0, 0, 0,  32'h0,     32'h0,     0,   0};
    vecs[4]  = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   1,  0,   32'h111,   2,   32'hB6,    1,    0, 0, 0,  32'h0,     32'h0,     0,   0};
    vecs[5]  = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 1, 0,  32'h111,   32'hB6,    0,   0};
    vecs[6]  = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   1,  0,   32'h222,   2,   32'hC7,    0,    0, 0, 0,  32'h0,     32'h0,     1,   0};
    vecs[7]  = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 0, 0,  32'h0,     32'h0,     1,   0};
    vecs[8]  = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   1,  2,   32'h0,     0,   32'h0,     0,    0, 0, 0,  32'h0,     32'h0,     1,   1};
    vecs[9]  = '{1, 0, 32'h10,    0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 1, 0,  32'h10,    32'h0,     0,   1};
    vecs[10] = '{1, 1, 32'h11,    1,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 1, 1,  32'h11,    32'h0,     0,   1};
    vecs[11] = '{1, 2, 32'h12,    2,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 1, 2,  32'h12,    32'hC7,    0,   1};
    vecs[12] = '{1, 3, 32'h13,    3,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 1, 3,  32'h13,    32'h0,     0,   1};
    vecs[13] = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    0, 0, 0,  32'h0,     32'h0,     0,   1};
    vecs[14] = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   1,  1,   32'h1234,  1,   32'h55,    1,    0, 0, 0,  32'h0,     32'h0,     0,   1};
    vecs[15] = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    0, 1, 1,  32'h1234,  32'h55,    0,   1};
    vecs[16] = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   1,  0,   32'h0,     0,   32'h0,     0,    0, 0, 0,  32'h0,     32'h0,     0,   1};
    vecs[17] = '{1, 0, 32'h77,    4,  0,  0,  32'h0,    1,   1,  3,   32'h0,     3,   32'h0,     0,    0, 0, 0,  32'h0,     32'h0,     0,   1};
    vecs[18] = '{1, 0, 32'h77,    4,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    1, 1, 0,  32'h77,    32'h0,     0,   1};
    vecs[19] = '{0, 0, 32'h0,     0,  0,  0,  32'h0,    1,   0,  0,   32'h0,     0,   32'h0,     0,    0, 0, 0,  32'h0,     32'h0,     0,   1};

    rst = 1'b1;
    quiet_inputs(1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_issue_valid", issue_valid, 0);
    chk("reset_issue_bus", issue_bus, 0);
    chk("reset_idle", idle, 1);
    chk("reset_wb_error", wb_error, 0);
    chk("reset_load_ready", load_ready, 1);
    chk("reset_host_wr_ready", host_wr_ready, 1);

    for (int r = 0; r < 20; r++) begin
      drive(vecs[r]);
      #2;
      chk($sformatf("v%0d_load_ready", r), load_ready, vecs[r].lr);
      chk($sformatf("v%0d_host_wr_ready", r), host_wr_ready, !vecs[r].wbv);
      step();
      chk($sformatf("v%0d_issue_valid", r), issue_valid, vecs[r].iv);
      chk($sformatf("v%0d_idle", r), idle, vecs[r].eidle);
      chk($sformatf("v%0d_wb_error", r), wb_error, vecs[r].err);
      if (vecs[r].iv) begin
        chk($sformatf("v%0d_id", r), issue_bus.system.id, vecs[r].iid);
        chk($sformatf("v%0d_thread", r), issue_bus.thread.u32[0], vecs[r].ithr);
        chk($sformatf("v%0d_data", r), issue_bus.data.u32[0], vecs[r].idat);
      end
    end

    // Stall hold, then back-to-back issue
    quiet_inputs(1'b1);
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst2_wb_error", wb_error, 0);
    chk("rst2_idle", idle, 1);
    for (int i = 0; i < 4; i++) begin
      quiet_inputs(1'b0);
      set_load(2'(i), 32'h20 + 32'(i), 3'(i));
      step();
      chk("hold_load_valid", issue_valid, 1);
      chk("hold_load_id", issue_bus.system.id, 0);
    end
    quiet_inputs(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", issue_valid, 1);
      chk("hold_id", issue_bus.system.id, 0);
      chk("hold_thread", issue_bus.thread.u32[0], 32'h20);
      chk("hold_active", issue_bus.system.active_thread, 1);
    end
    issue_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("b2b_valid", issue_valid, 1);
      chk("b2b_id", issue_bus.system.id, 64'(i));
      chk("b2b_thread", issue_bus.thread.u32[0], 32'h20 + 32'(i));
    end
    step();
    chk("b2b_drain", issue_valid, 0);

    // Writeback then same-cycle host data/shared write bypass into the capture
    quiet_inputs(1'b1);
    set_wb(2'd2, 32'h2, 3'd5, 32'h0, 1'b1);
    step();
    chk("byp_wb_cycle_valid", issue_valid, 0);
    quiet_inputs(1'b1);
    data_wr_en = 1'b1; data_wr_addr = 3'd5; data_wr_value.u32[0] = 32'h99;
    shared_wr_en = 1'b1; shared_wr_value.u32[0] = 32'h5A;
    #2 chk("byp_host_wr_ready", host_wr_ready, 1);
    step();
    chk("byp_valid", issue_valid, 1);
    chk("byp_id", issue_bus.system.id, 2);
    chk("byp_daddr", issue_bus.system.data_address, 5);
    chk("byp_thread", issue_bus.thread.u32[0], 32'h2);
    chk("byp_data", issue_bus.data.u32[0], 32'h99);
    chk("byp_shared", issue_bus.shared.u32[0], 32'h5A);

    // Reset mid-run drops in-flight bookkeeping; stale writeback is an error
    quiet_inputs(1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_valid", issue_valid, 0);
    chk("midrst_idle", idle, 1);
    step();
    rst = 1'b0;
    set_wb(2'd1, 32'h0, 3'd0, 32'h0, 1'b1);
    step();
    chk("midrst_wb_error", wb_error, 1);
    chk("midrst_idle_after_wb", idle, 1);
    quiet_inputs(1'b1);
    step();
    chk("midrst_wb_error_sticky", wb_error, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_issue_stage.md
# pipeline_issue_stage

Per-thread context store and issue stage at the head of the lcisc execution pipeline. It holds the thread register, instructions and data address of every context thread, plus the shared register and data storage. It selects ready threads round-robin and emits a fully assembled `EV_types::pipeline_pass_structure_t` to the pipeline. It also consumes the pipeline-tail writeback of that structure and commits it back to storage.

## Interface
Parameters:
- `THREADS`, default `EV_types::ContextThreadLength`: number of context threads; must be a power of two and ≥ 2.
- `DATA_DEPTH`, default `EV_types::DataStorageLength`: number of data registers.

Ports (`PPS` = `$bits(pipeline_pass_structure_t)`):
- `clk` input, 1: single clock; all state on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `load_valid` input, 1: host initialises one thread context.
- `load_ready` output, 1: load accepted this cycle when high together with `load_valid`.
- `load_id` input, `thread_id_t`: target thread.
- `load_thread` input, `thread_register_size`: initial thread register.
- `load_instr` input, `program_instruction_size`: program instructions.
- `load_data_address` input, `data_address_t`: data register bound to the thread.
- `host_wr_ready` output, 1: host data/shared writes accepted.
- `data_wr_en` input, 1: host write to the data storage.
- `data_wr_addr` input, `data_address_t`: data storage index.
- `data_wr_value` input, `data_register_size`: data value.
- `shared_wr_en` input, 1: host write to the shared register.
- `shared_wr_value` input, `shared_register_size`: shared value.
- `issue_valid` output, 1: `issue_bus` holds a thread ready for the pipeline.
- `issue_ready` input, 1: pipeline accepts `issue_bus`.
- `issue_bus` output, PPS: assembled pass structure.
- `wb_valid` input, 1: pipeline-tail writeback present.
- `wb_bus` input, PPS: written-back pass structure.
- `idle` output, 1: no thread active and none in flight.
- `wb_error` output, 1: sticky flag; a writeback arrived for a thread that was not in flight.

## Operation
- State per thread:
  - `active` bit and `inflight` bit.
  - Thread register, instructions and data address.
- Shared state: one shared register; data array of `DATA_DEPTH` entries; round-robin pointer `rr`.
- Load:
  - `load_ready = !inflight[load_id] && !wb_valid`.
  - On accept: write the thread register, instructions and data address; set `active[load_id]=1`.
- Host writes:
  - `host_wr_ready = !wb_valid`.
  - Data and shared writes are committed only when ready; writes offered while not ready are dropped, and the host must hold them.
- Candidate selection:
  - Scan from `rr+1`, wrapping modulo `THREADS`, for the first thread with `active && !inflight`.
  - Exclude the thread being handed over this cycle.
- Issue register:
  - Reloads when `!issue_valid || issue_ready`.
  - If a candidate exists: `issue_valid=1`, and `issue_bus` is set as follows.
    - `system.active_thread=1`, `system.id=cand`, `system.data_address` = the thread's data address.
    - `thread`, `instuctions`: from the thread context.
    - `shared`: the current shared register.
    - `data`: `data[data_address]`.
    - Also set `inflight[cand]=1` and `rr=cand`.
  - If no candidate exists: `issue_valid=0`.
  - While `issue_valid && !issue_ready`, `issue_bus` is held bit-stable.
- Bypass: if a writeback or host write updates a thread context, the shared register, or the data entry being captured into the issue register in the same cycle, the issue register captures the new value.
- Writeback, on `wb_valid` with `id = wb_bus.system.id`:
  - If `inflight[id]`:
    - Store `wb_bus.thread`, `instuctions` and `system.data_address` to the context.
    - `shared <= wb_bus.shared`.
    - `data[wb_bus.system.data_address] <= wb_bus.data`.
    - `active[id] <= wb_bus.system.active_thread`; clear `inflight[id]`.
  - Else: no state change; set `wb_error`.
- Priority:
  - Writeback over host writes and loads; both are stalled via their ready signals.
  - A thread freed by writeback becomes a candidate in the next cycle.
- `idle = !(|active) && !(|inflight)`.

## Timing
- Reset values:
  - `issue_valid=0`, `issue_bus=0`, `wb_error=0`, `idle=1`.
  - `load_ready=1` and `host_wr_ready=1` when `wb_valid=0`.
  - All `active`/`inflight` bits 0, `rr=THREADS-1`, all storage 0.
- Reset asserted mid-operation discards in-flight bookkeeping immediately; later writebacks set `wb_error`.
- Latencies:
  - Load accepted in cycle N → `issue_valid` rises at N+1 (thread idle, issue register empty).
  - Writeback in cycle N → the same thread can be issued at N+2.
- Issue throughput: one thread per cycle with `issue_ready` held high, given enough ready threads.
- Back-to-back accepted issues carry distinct ids.
- A single active thread re-issues only after its writeback.

## Test plan
- Reset, load thread 0 with data_address 2 and `data[2]=0xA5`; `issue_ready=1` → `issue_valid` at cycle+1 with `id=0`, `data.u32[0]=0xA5`; `inflight[0]` set; no second issue.
- Load threads 0–3 (`THREADS=4`); `issue_ready=1` → ids 0,1,2,3 on consecutive cycles; then `issue_valid=0`.
- Hold `issue_ready=0` for 5 cycles → `issue_bus` unchanged.
- Writeback id 1 with `thread.u32[0]=0x1234` and `active_thread=1` → re-issue of 1 two cycles later carries `0x1234`.
- Writeback with `active_thread=0` for the last in-flight thread → that thread is never re-issued; `idle=1` after the commit.
- Writeback for id 2 while not in flight → `wb_error=1` and stays 1.
- `wb_valid` and `load_valid` in the same cycle → `load_ready=0`; the load completes the following cycle.
- Host data write to the address being captured, same cycle → `issue_bus.data` shows the new value.
